// File: rtl/blink_pkg.sv
// Shared constants, cell permutation and FSM encoding for the Blink-64
// round controller and its shuffle network.
package blink_pkg;

  localparam int BLINK_N      = 64;
  localparam int BLINK_CELL_W = 4;
  localparam int BLINK_CELLS  = 16;

  // Forward shuffle: out cell i takes in cell BLINK_PERM[i].
  localparam int BLINK_PERM [BLINK_CELLS] = '{
    0, 5, 11, 10, 1, 6, 4, 13, 2, 12, 9, 15, 3, 7, 14, 8
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } blink_state_e;

endpackage

// File: rtl/blink_cell_shuffle.sv
// Blink-64 cell shuffle network; INV = 0 is the forward shuffle, INV = 1 its
// inverse. Pure wiring, no logic gates.
module blink_cell_shuffle
  import blink_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  logic [BLINK_N-1:0] data_i,
  output logic [BLINK_N-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < BLINK_CELLS; i++) begin
      if (INV) begin
        data_o[BLINK_CELL_W*BLINK_PERM[i] +: BLINK_CELL_W] = data_i[BLINK_CELL_W*i +: BLINK_CELL_W];
      end else begin
        data_o[BLINK_CELL_W*i +: BLINK_CELL_W] = data_i[BLINK_CELL_W*BLINK_PERM[i] +: BLINK_CELL_W];
      end
    end
  end

endmodule

// File: rtl/blink64_round_ctrl.sv
// Iterative Blink-64 round controller: owns the 64-bit state and round counter,
// drives the external round function and applies the cell shuffle each round.
// Define BLINK_ROUND_CTRL_ABORT_EN to add the abort input.
module blink64_round_ctrl
  import blink_pkg::*;
#(
  parameter int ROUNDS = 16,  // 1..31
  parameter int RW     = 5    // 2**RW must exceed ROUNDS
) (
  input  logic               clk,
  input  logic               rst,
  // Handshakes: a transfer happens on an edge where valid && ready; valid
  // never waits on ready, and data is held stable while valid is high.
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_dec,
  input  logic [BLINK_N-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLINK_N-1:0] out_data,
  output logic [BLINK_N-1:0] rf_state,
  output logic [RW-1:0]      rf_round,
  output logic               rf_dec,
  input  logic [BLINK_N-1:0] rf_result,
  output logic               busy,
`ifdef BLINK_ROUND_CTRL_ABORT_EN
  input  logic               abort,
`endif
  output blink_state_e       dbg_state_o
);

  localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

  blink_state_e       fsm_q, fsm_d;
  logic [BLINK_N-1:0] state_q, state_d;
  logic [RW-1:0]      round_q, round_d;
  logic               dec_q, dec_d;
  logic [BLINK_N-1:0] fwd_result;
  logic [BLINK_N-1:0] inv_state;
  logic               last_round;
  logic               abort_hit;

  blink_cell_shuffle #(.INV(1'b0)) u_fwd (
    .data_i (rf_result),
    .data_o (fwd_result)
  );

  blink_cell_shuffle #(.INV(1'b1)) u_inv (
    .data_i (state_q),
    .data_o (inv_state)
  );

`ifdef BLINK_ROUND_CTRL_ABORT_EN
  assign abort_hit = abort && (fsm_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign last_round = dec_q ? (round_q == '0) : (round_q == LAST_RND);

  // Encrypt shuffles after the round function, decrypt un-shuffles before it.
  assign rf_state = dec_q ? inv_state : state_q;
  assign rf_round = round_q;
  assign rf_dec   = dec_q;
  assign out_data = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (in_valid)   fsm_d = RUN;
      RUN:     if (last_round) fsm_d = DONE;
      DONE:    if (out_ready)  fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    if (abort_hit) fsm_d = IDLE;
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    dec_d   = dec_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          dec_d   = in_dec;
          round_d = in_dec ? LAST_RND : '0;
        end
      end
      RUN: begin
        state_d = dec_q ? rf_result : fwd_result;
        // Counter parks on its final value so DONE shows the last round index.
        if (!last_round) begin
          round_d = dec_q ? (round_q - RW'(1)) : (round_q + RW'(1));
        end
      end
      default: ;
    endcase
    if (abort_hit) begin
      state_d = '0;
      round_d = '0;
    end
  end

  always_comb begin
    in_ready    = (fsm_q == IDLE) && !rst;
    out_valid   = (fsm_q == DONE);
    busy        = (fsm_q == RUN);
    dbg_state_o = fsm_q;
  end

endmodule

// File: tb/tb_blink64_round_ctrl.sv
// Self-checking bench for blink64_round_ctrl: a 1-round instance with an
// identity round function and a 16-round instance with an XOR-round function.
module tb_blink64_round_ctrl;
  import blink_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-round instance
  logic         in_valid, in_ready, in_dec, out_valid, out_ready, rf_dec, busy;
  logic [63:0]  in_data, out_data, rf_state, rf_result;
  logic [4:0]   rf_round;
  blink_state_e dbg_state;
  // 1-round instance
  logic         in_valid1, in_ready1, in_dec1, out_valid1, out_ready1, rf_dec1, busy1;
  logic [63:0]  in_data1, out_data1, rf_state1, rf_result1;
  logic [4:0]   rf_round1;
  blink_state_e dbg_state1;
`ifdef BLINK_ROUND_CTRL_ABORT_EN
  logic abort, abort1;
`endif

  assign rf_result  = rf_state ^ {59'b0, rf_round};
  assign rf_result1 = rf_state1;

  blink64_round_ctrl #(.ROUNDS(16), .RW(5)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rf_state(rf_state), .rf_round(rf_round), .rf_dec(rf_dec), .rf_result(rf_result),
    .busy(busy),
`ifdef BLINK_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .dbg_state_o(dbg_state)
  );

  blink64_round_ctrl #(.ROUNDS(1), .RW(5)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_dec(in_dec1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .rf_state(rf_state1), .rf_round(rf_round1), .rf_dec(rf_dec1), .rf_result(rf_result1),
    .busy(busy1),
`ifdef BLINK_ROUND_CTRL_ABORT_EN
    .abort(abort1),
`endif
    .dbg_state_o(dbg_state1)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  int          perm [16] = '{0, 5, 11, 10, 1, 6, 4, 13, 2, 12, 9, 15, 3, 7, 14, 8};
  int          inv_perm [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: cell i of the result is cell src(i) of the input.
  function automatic logic [63:0] shuf(input logic [63:0] x, input bit inv);
    logic [63:0] y;
    int src;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      src = inv ? inv_perm[i] : perm[i];
      y[4*i +: 4] = x[4*src +: 4];
    end
    return y;
  endfunction

  function automatic logic [63:0] enc_model(input logic [63:0] x, input int rounds);
    for (int r = 0; r < rounds; r++) x = shuf(x ^ 64'(r), 1'b0);
    return x;
  endfunction

  function automatic logic [63:0] dec_model(input logic [63:0] x, input int rounds);
    for (int r = rounds - 1; r >= 0; r--) x = shuf(x, 1'b1) ^ 64'(r);
    return x;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic run1(input bit dec, input logic [63:0] din, input logic [63:0] expv);
    in_valid1 = 1'b1; in_dec1 = dec; in_data1 = din;
    tick();
    in_valid1 = 1'b0;
    check("busy1_after_accept", busy1, 1'b1);
    check("rf_round1", rf_round1, 5'd0);
    tick();
    check("valid1_latency", out_valid1, 1'b1);
    check("data1", out_data1, expv);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("idle1_after_xfer", in_ready1, 1'b1);
  endtask

  // One 16-round block; hold = cycles of out_ready back-pressure in DONE.
  task automatic run16(input bit dec, input logic [63:0] din, input int hold,
                       output logic [63:0] dout);
    logic [4:0]  seen[$];
    logic [63:0] expv;
    int cyc;
    expv = dec ? dec_model(din, 16) : enc_model(din, 16);
    exp_q.push_back(expv);
    check("in_ready_before", in_ready, 1'b1);
    in_valid = 1'b1; in_dec = dec; in_data = din;
    tick();
    in_valid = 1'b0; in_data = rand64();
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) seen.push_back(rf_round);
      tick();
      cyc++;
    end
    check("latency16", 64'(cyc), 64'd16);
    check("round_count", 64'(seen.size()), 64'd16);
    for (int i = 0; i < seen.size() && i < 16; i++)
      check("rf_round_seq", seen[i], dec ? 5'(15 - i) : 5'(i));
    check("rf_dec", rf_dec, dec);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, expv);
      check("hold_in_ready", in_ready, 1'b0);
      in_valid = 1'($urandom_range(0, 1));
      in_dec   = 1'($urandom_range(0, 1));
      in_data  = rand64();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("out_data", out_data, exp_q.pop_front());
    dout = out_data;
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 1'b0);
    check("no_stray_accept", busy, 1'b0);
  endtask

  initial begin
    logic [63:0] x, y, z;
    int cyc, cnt;
    for (int i = 0; i < 16; i++) inv_perm[perm[i]] = i;
    in_valid = 0; in_dec = 0; in_data = '0; out_ready = 0;
    in_valid1 = 0; in_dec1 = 0; in_data1 = '0; out_ready1 = 0;
`ifdef BLINK_ROUND_CTRL_ABORT_EN
    abort = 0; abort1 = 0;
`endif
    rst = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_in_ready1", in_ready1, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_state", out_data, 64'd0);
    check("post_rst_round", rf_round, 5'd0);
    check("post_rst_dec", rf_dec, 1'b0);
    check("post_rst_in_ready1", in_ready1, 1'b1);

    run1(1'b0, 64'hFEDCBA9876543210, 64'h8E73F9C2D461AB50);
    run1(1'b1, 64'h8E73F9C2D461AB50, 64'hFEDCBA9876543210);

    for (int k = 0; k < 6; k++) begin
      x = rand64();
      run16(1'b0, x, $urandom_range(0, 3), y);
      run16(1'b1, y, $urandom_range(0, 3), z);
      check("roundtrip", z, x);
    end

    run16(1'b0, rand64(), 5, y);

    // Reset in the middle of a block.
    in_valid = 1'b1; in_dec = 1'b0; in_data = rand64();
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (rf_round != 5'd7 && cyc < 40) begin tick(); cyc++; end
    check("reach_round7", rf_round, 5'd7);
    rst = 1'b1;
    tick();
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_state", out_data, 64'd0);
    check("midrst_round", rf_round, 5'd0);
    check("midrst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready_after", in_ready, 1'b1);
    cnt = 0;
    repeat (20) begin tick(); if (out_valid) cnt++; end
    check("midrst_no_valid", 64'(cnt), 64'd0);
    x = rand64();
    run16(1'b0, x, 0, y);
    run16(1'b1, y, 1, z);
    check("post_rst_roundtrip", z, x);

`ifdef BLINK_ROUND_CTRL_ABORT_EN
    in_valid = 1'b1; in_dec = 1'b0; in_data = rand64();
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (rf_round != 5'd3 && cyc < 40) begin tick(); cyc++; end
    check("reach_round3", rf_round, 5'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_state", out_data, 64'd0);
    check("abort_in_ready", in_ready, 1'b1);
    cnt = 0;
    repeat (20) begin tick(); if (out_valid) cnt++; end
    check("abort_no_valid", 64'(cnt), 64'd0);

    in_valid = 1'b1; in_dec = 1'b0; in_data = rand64();
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    check("abort_done_reached", out_valid, 1'b1);
    abort = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b0;
    check("abort_done_state", out_data, 64'd0);
    check("abort_done_valid", out_valid, 1'b0);
    check("abort_done_in_ready", in_ready, 1'b1);

    x = rand64();
    abort = 1'b1; in_valid = 1'b1; in_dec = 1'b0; in_data = x;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_idle_accept", busy, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    check("abort_idle_result", out_data, enc_model(x, 16));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/blink64_round_ctrl.md
Name: blink64_round_ctrl

Overview:
Iterative round controller for the Blink-64 permutation datapath.
- Owns the 64-bit state register and the round counter.
- Exposes a combinational round-function hook (add-key/S-box/mix, implemented outside this block).
- Applies the cell shuffle (forward for encrypt, inverse for decrypt) each round.
- Frames one block per transaction with valid/ready handshakes.
- Sits between the block-level I/O wrapper and the round-function datapath.

Parameters:
- ROUNDS, 16, number of rounds per block (1..31).
- RW, 5, round-counter width; must satisfy 2**RW > ROUNDS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  controller can accept a block.
- in_dec  in  1  direction: 0 = encrypt, 1 = decrypt; sampled on accept.
- in_data  in  64  input block.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  64  result block.
- rf_state  out  64  state presented to the round function.
- rf_round  out  RW  current round index.
- rf_dec  out  1  latched direction.
- rf_result  in  64  round-function output; combinational from rf_state, rf_round, rf_dec.
- busy  out  1  high in RUN.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- Reset values: state = IDLE, in_ready = 0 during reset and 1 in the first cycle after, out_valid = 0, busy = 0, state_q = 0, round_q = 0, dec_q = 0.
- Shuffle permutation (cell i = bits 4i+3:4i):
  - Forward shuffle: out cell i = in cell perm[i].
  - perm = 0,5,11,10,1,6,4,13,2,12,9,15,3,7,14,8.
  - Inverse shuffle: out cell perm[i] = in cell i.
- IDLE:
  - in_ready = 1.
  - On in_valid: state_q <= in_data, dec_q <= in_dec, round_q <= 0 (encrypt) or ROUNDS-1 (decrypt); go to RUN.
- RUN:
  - in_ready = 0, busy = 1.
  - Encrypt round: rf_state = state_q; state_q <= Shuffle(rf_result).
  - Decrypt round: rf_state = InvShuffle(state_q); state_q <= rf_result.
  - Encrypt counter: round_q increments; the last round is round_q == ROUNDS-1.
  - Decrypt counter: round_q decrements; the last round is round_q == 0.
  - After the last round: go to DONE.
  - Exactly ROUNDS RUN cycles per block.
- DONE:
  - out_valid = 1, out_data = state_q.
  - out_data is held stable until out_ready.
  - On out_ready: go to IDLE.
- Latency: accept at edge N gives out_valid at edge N+ROUNDS. Throughput is one block per ROUNDS+2 cycles minimum.
- out_data = state_q at all times; it is only meaningful while out_valid = 1.
- rf_round and rf_dec are driven from registers only; no combinational path from in_* to rf_*.
- in_valid outside IDLE is ignored and not back-pressured; in_ready = 0 is the back-pressure.
- out_ready outside DONE is ignored.
- rst asserted mid-RUN or in DONE: return to reset values next cycle; the in-flight block is dropped and no out_valid pulse is produced.
- The decrypt sequence exactly inverts the encrypt sequence when the round function is invertible per (round, dir).

Optional Feature:
- Macro: BLINK_ROUND_CTRL_ABORT_EN.
- With the macro defined:
  - Adds input abort (1 bit).
  - abort = 1 in RUN or DONE forces IDLE next cycle; out_valid is never raised for that block; state_q is cleared to 0.
  - abort in IDLE has no effect.
  - abort has priority over the round update and over the out_ready handshake.
- Without the macro: no abort port; every accepted block completes.

Decomposition:
- Shared package blink_pkg:
  - BLINK_N = 64, BLINK_CELL_W = 4, BLINK_CELLS = 16.
  - BLINK_PERM constant array.
  - FSM state enum (IDLE/RUN/DONE).
- Natural sub-module: the shuffle network, blink_cell_shuffle, with parameter INV selecting forward or inverse; instantiated twice.

Test Plan:
- Encrypt, forward-shuffle check: ROUNDS=1, rf_result = rf_state, encrypt in_data 64'hFEDCBA9876543210 -> out_data 64'h8E73F9C2D461AB50, out_valid exactly 1 cycle after accept.
- Decrypt, inverse-shuffle check: ROUNDS=1, identity rf, decrypt 64'h8E73F9C2D461AB50 -> 64'hFEDCBA9876543210.
- Round sequencing: ROUNDS=16, rf_result = rf_state ^ {59'b0, rf_round}.
  - rf_round sequence is 0..15 for encrypt and 15..0 for decrypt.
  - Encrypt then decrypt of random blocks returns the original; out_valid exactly 16 cycles after accept.
- Back-pressure: hold out_ready = 0 for 5 cycles in DONE -> out_data stable and in_ready = 0 throughout; in_valid pulses in that window are ignored.
- Reset mid-operation: rst at round 7 -> next cycle IDLE, out_valid = 0, state_q = 0; a new block then completes normally.
- Abort (BLINK_ROUND_CTRL_ABORT_EN): abort at round 3 -> IDLE next cycle, no out_valid; abort coincident with out_ready in DONE -> abort wins, no transfer counted.
